ex_latency_monitor: RTL and testbench

//  Synthesisable, parametrised EX-stage latency monitor for cv32e40p; sits beside ex_stage, taps EX_Interface signals.

---
 rtl/ex_latency_monitor.sv | 239 +++++++++++++++++++++++
 tb/tb_ex_latency_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_latency_monitor.sv
// EX-stage latency monitor: classifies accepted ALU/MULT ops, times issue-to-valid,
// and reports latency/handshake violations with sticky per-class flags and issue counters.
module ex_latency_monitor #(
    parameter int CNT_W        = 16,
    parameter int LAT_W        = 6,
    parameter int DIV_MIN      = 2,
    parameter int DIV_MAX      = 34,
    parameter int DIV_ZERO_LAT = 34,
    parameter int MULH_LAT     = 4,
    parameter int ALU_OP_WIDTH = 7,
    parameter int MUL_OP_WIDTH = 3,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_DIVU  = 7'b0110000,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_REMU  = 7'b0110010,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011,
    parameter logic [MUL_OP_WIDTH-1:0] MUL_MAC32 = 3'b000,
    parameter logic [MUL_OP_WIDTH-1:0] MUL_H     = 3'b110
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_en_i,
    input  logic [ALU_OP_WIDTH-1:0] alu_operator_i,
    input  logic                    mult_en_i,
    input  logic [MUL_OP_WIDTH-1:0] mult_operator_i,
    input  logic                    lsu_en_i,
    input  logic                    div_zero_i,
    input  logic                    ex_ready_i,
    input  logic                    ex_valid_i,
    input  logic                    mult_multicycle_i,
    input  logic                    clr_i,
    output logic                    err_o,
    output logic [2:0]              err_code_o,
    output logic [1:0]              err_class_o,
    output logic [3:0]              err_sticky_o,
    output logic [LAT_W-1:0]        lat_last_o,
    output logic [4*CNT_W-1:0]      issue_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT_DIV, WAIT_MULH} state_e;

    localparam logic [2:0] E_EARLY   = 3'd1;
    localparam logic [2:0] E_LATE    = 3'd2;
    localparam logic [2:0] E_NOVALID = 3'd3;
    localparam logic [2:0] E_MCYC    = 3'd4;
    localparam logic [2:0] E_OVERLAP = 3'd5;

    localparam logic [LAT_W-1:0] L_DIV_MIN  = LAT_W'(DIV_MIN);
    localparam logic [LAT_W-1:0] L_DIV_TO   = LAT_W'(DIV_MAX + 1);
    localparam logic [LAT_W-1:0] L_DZ_LAT   = LAT_W'(DIV_ZERO_LAT);
    localparam logic [LAT_W-1:0] L_MULH_LAT = LAT_W'(MULH_LAT);

    state_e                      state_q, state_d;
    logic [LAT_W-1:0]            lat_q, lat_d;
    logic                        dz_q, dz_d;
    logic                        ready_q;
    logic                        err_q;
    logic [2:0]                  code_q, code_d;
    logic [1:0]                  class_q, class_d;
    logic [3:0]                  sticky_q, sticky_d;
    logic [LAT_W-1:0]            lat_last_q, lat_last_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;

    logic       issue, is_div, cls_vld;
    logic [1:0] cls;
    logic       err_det;
    logic [2:0] det_code;
    logic [1:0] det_cls;

    assign issue  = (alu_en_i | mult_en_i) & ready_q;
    assign is_div = alu_operator_i inside {ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};

    // ALU takes priority if both enables are seen; unclassified ops leave cls_vld low.
    always_comb begin
        cls_vld = 1'b0;
        cls     = 2'd0;
        if (alu_en_i) begin
            if (is_div) begin
                cls_vld = 1'b1;
                cls     = 2'd1;
            end else if (!lsu_en_i) begin
                cls_vld = 1'b1;
                cls     = 2'd0;
            end
        end else if (mult_en_i) begin
            if (mult_operator_i == MUL_MAC32) begin
                cls_vld = 1'b1;
                cls     = 2'd2;
            end else if (mult_operator_i == MUL_H) begin
                cls_vld = 1'b1;
                cls     = 2'd3;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        dz_d       = dz_q;
        lat_last_d = lat_last_q;
        err_det    = 1'b0;
        det_code   = 3'd0;
        det_cls    = cls;
        case (state_q)
            IDLE: begin
                if (issue && cls_vld) begin
                    case (cls)
                        2'd0: if (!ex_valid_i) begin
                            err_det  = 1'b1;
                            det_code = E_NOVALID;
                        end
                        2'd2: if (!ex_valid_i) begin
                            err_det  = 1'b1;
                            det_code = E_NOVALID;
                        end else if (mult_multicycle_i) begin
                            err_det  = 1'b1;
                            det_code = E_MCYC;
                        end
                        2'd1: if (ex_valid_i) begin
                            err_det  = 1'b1;
                            det_code = E_EARLY;
                        end else begin
                            state_d = WAIT_DIV;
                            lat_d   = LAT_W'(1);
                            dz_d    = div_zero_i;
                        end
                        default: if (ex_valid_i) begin
                            err_det  = 1'b1;
                            det_code = E_EARLY;
                        end else begin
                            state_d = WAIT_MULH;
                            lat_d   = LAT_W'(1);
                        end
                    endcase
                end
            end
            WAIT_DIV: begin
                det_cls = 2'd1;
                if (issue) begin
                    err_det  = 1'b1;
                    det_code = E_OVERLAP;
                    state_d  = IDLE;
                end else if (ex_valid_i) begin
                    state_d    = IDLE;
                    lat_last_d = lat_q;
                    if (lat_q < L_DIV_MIN) begin
                        err_det  = 1'b1;
                        det_code = E_EARLY;
                    end else if (dz_q && lat_q != L_DZ_LAT) begin
                        err_det  = 1'b1;
                        det_code = (lat_q < L_DZ_LAT) ? E_EARLY : E_LATE;
                    end
                end else if (lat_q == L_DIV_TO) begin
                    err_det  = 1'b1;
                    det_code = E_LATE;
                    state_d  = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            WAIT_MULH: begin
                det_cls = 2'd3;
                if (issue) begin
                    err_det  = 1'b1;
                    det_code = E_OVERLAP;
                    state_d  = IDLE;
                end else if (ex_valid_i) begin
                    state_d    = IDLE;
                    lat_last_d = lat_q;
                    if (lat_q < L_MULH_LAT) begin
                        err_det  = 1'b1;
                        det_code = E_EARLY;
                    end
                end else if (lat_q < L_MULH_LAT && !mult_multicycle_i) begin
                    err_det  = 1'b1;
                    det_code = E_MCYC;
                    state_d  = IDLE;
                end else if (lat_q >= L_MULH_LAT) begin
                    err_det  = 1'b1;
                    det_code = E_LATE;
                    state_d  = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle error overrides clr_i so the new fault is not lost.
    always_comb begin
        code_d   = clr_i ? 3'd0 : code_q;
        class_d  = clr_i ? 2'd0 : class_q;
        sticky_d = clr_i ? 4'd0 : sticky_q;
        if (err_det) begin
            code_d            = det_code;
            class_d           = det_cls;
            sticky_d[det_cls] = 1'b1;
        end
        for (int c = 0; c < 4; c++) begin
            cnt_d[c] = clr_i ? '0 : cnt_q[c];
            if (issue && cls_vld && cls == 2'(c) && cnt_d[c] != '1)
                cnt_d[c] = cnt_d[c] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            dz_q       <= 1'b0;
            ready_q    <= 1'b1;
            err_q      <= 1'b0;
            code_q     <= '0;
            class_q    <= '0;
            sticky_q   <= '0;
            lat_last_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            dz_q       <= dz_d;
            ready_q    <= ex_ready_i;
            err_q      <= err_det;
            code_q     <= code_d;
            class_q    <= class_d;
            sticky_q   <= sticky_d;
            lat_last_q <= lat_last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign err_class_o  = class_q;
    assign err_sticky_o = sticky_q;
    assign lat_last_o   = lat_last_q;
    assign issue_cnt_o  = cnt_q;

endmodule

// File: tb/tb_ex_latency_monitor.sv
// Scoreboard bench for ex_latency_monitor: expected error events are queued at stimulus
// time and matched against each err_o pulse; counters, latency and sticky bits checked directly.
module tb_ex_latency_monitor;

    localparam logic [6:0] ALU_ADD   = 7'b0011000;
    localparam logic [6:0] ALU_DIV   = 7'b0110001;
    localparam logic [6:0] ALU_DIVU  = 7'b0110000;
    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_H     = 3'b110;

    typedef struct {
        logic [2:0] code;
        logic [1:0] cls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, alu_en, mult_en, lsu_en, div_zero, ex_ready, ex_valid, mcyc, clr;
    logic [6:0]  alu_op;
    logic [2:0]  mul_op;
    logic        err_o;
    logic [2:0]  err_code;
    logic [1:0]  err_class;
    logic [3:0]  err_sticky;
    logic [5:0]  lat_last;
    logic [63:0] issue_cnt;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt[4];
    logic [3:0] exp_sticky = 4'd0;

    ex_latency_monitor dut (
        .clk(clk), .rst(rst),
        .alu_en_i(alu_en), .alu_operator_i(alu_op),
        .mult_en_i(mult_en), .mult_operator_i(mul_op),
        .lsu_en_i(lsu_en), .div_zero_i(div_zero),
        .ex_ready_i(ex_ready), .ex_valid_i(ex_valid),
        .mult_multicycle_i(mcyc), .clr_i(clr),
        .err_o(err_o), .err_code_o(err_code), .err_class_o(err_class),
        .err_sticky_o(err_sticky), .lat_last_o(lat_last), .issue_cnt_o(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every err_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (err_o) begin
            if (sb.size() == 0) begin
                chk("err_o_unexpected", err_o, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("err_code", err_code, e.code);
                chk("err_class", err_class, e.cls);
                chk("err_sticky", err_sticky, exp_sticky);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_err(input logic [2:0] code, input logic [1:0] cls);
        exp_t e;
        e.code = code;
        e.cls  = cls;
        sb.push_back(e);
        exp_sticky[cls] = 1'b1;
    endtask

    task automatic bump(input int c);
        if (exp_cnt[c] < 65535) exp_cnt[c]++;
    endtask

    task automatic clear_inputs();
        alu_en = 0; mult_en = 0; lsu_en = 0; div_zero = 0;
        ex_valid = 0; mcyc = 0; clr = 0;
    endtask

    task automatic settle(input string tag);
        tick();
        tick();
        chk(tag, sb.size(), 0);
    endtask

    task automatic chk_cnt();
        for (int c = 0; c < 4; c++)
            chk($sformatf("issue_cnt%0d", c), issue_cnt[c*16 +: 16], exp_cnt[c]);
    endtask

    task automatic do_alu(input logic [6:0] op, input logic vld, input logic lsu);
        alu_en = 1; alu_op = op; ex_valid = vld; lsu_en = lsu; ex_ready = 1;
        if (!lsu) begin
            bump(0);
            if (!vld) expect_err(3'd3, 2'd0);
        end
        tick();
        clear_inputs();
    endtask

    task automatic do_mul(input logic [2:0] op, input logic vld, input logic mc);
        mult_en = 1; mul_op = op; ex_valid = vld; mcyc = mc; ex_ready = 1;
        if (op == MUL_MAC32) begin
            bump(2);
            if (!vld) expect_err(3'd3, 2'd2);
            else if (mc) expect_err(3'd4, 2'd2);
        end
        tick();
        clear_inputs();
    endtask

    // vlat==0: valid never arrives.
    task automatic do_div(input logic [6:0] op, input logic dz, input int vlat);
        bump(1);
        if (vlat == 0) expect_err(3'd2, 2'd1);
        else if (vlat < 2) expect_err(3'd1, 2'd1);
        else if (dz && vlat != 34) expect_err((vlat < 34) ? 3'd1 : 3'd2, 2'd1);
        alu_en = 1; alu_op = op; div_zero = dz; ex_ready = 0; ex_valid = 0;
        tick();
        clear_inputs();
        if (vlat == 0) begin
            for (int l = 1; l < 35; l++) tick();
            chk("div_timeout_not_before_36", err_o, 1'b0);
            tick();
            chk("div_timeout_at_36", err_o, 1'b1);
        end else begin
            for (int l = 1; l < vlat; l++) tick();
            ex_valid = 1;
            ex_ready = 1;
            tick();
            ex_valid = 0;
            chk($sformatf("div_lat_last_%0d", vlat), lat_last, vlat);
        end
        ex_ready = 1;
    endtask

    // drop==0: clean MUL_H; otherwise multicycle falls at lat 'drop'.
    task automatic do_mulh(input int drop);
        bump(3);
        mult_en = 1; mul_op = MUL_H; ex_ready = 0;
        tick();
        clear_inputs();
        for (int l = 1; l < 4; l++) begin
            mcyc = (drop == 0 || l < drop);
            if (l == drop) begin
                expect_err(3'd4, 2'd3);
                tick();
                clear_inputs();
                ex_ready = 1;
                return;
            end
            tick();
        end
        mcyc = 0; ex_valid = 1; ex_ready = 1;
        tick();
        ex_valid = 0;
        chk("mulh_lat_last", lat_last, 4);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        alu_op = ALU_ADD; mul_op = MUL_MAC32;
        clear_inputs();
        rst = 1; ex_ready = 0;
        repeat (3) tick();
        chk("rst_err_o", err_o, 0);
        chk("rst_code", err_code, 0);
        chk("rst_class", err_class, 0);
        chk("rst_sticky", err_sticky, 0);
        chk("rst_lat_last", lat_last, 0);
        chk("rst_cnt", issue_cnt, 64'd0);

        // ready_q comes out of reset high, so the first op is accepted even with ex_ready low.
        rst = 0; alu_en = 1; alu_op = ALU_ADD; ex_valid = 1;
        bump(0);
        tick();
        clear_inputs();
        ex_ready = 1;
        tick();
        chk_cnt();

        do_alu(ALU_ADD, 1, 0);
        do_alu(ALU_ADD, 0, 0);
        do_alu(ALU_ADD, 0, 1);
        settle("sb_alu");
        chk_cnt();

        do_mul(MUL_MAC32, 1, 0);
        do_mul(MUL_MAC32, 1, 1);
        do_mul(MUL_MAC32, 0, 0);
        settle("sb_mul");

        do_div(ALU_DIV, 0, 10);
        do_alu(ALU_ADD, 1, 0);
        settle("sb_back_to_back");
        do_div(ALU_DIV, 0, 1);
        settle("sb_div_early");
        do_div(ALU_DIVU, 1, 34);
        do_div(ALU_DIVU, 1, 20);
        settle("sb_div_zero");

        do_mulh(0);
        do_mulh(2);
        settle("sb_mulh");
        chk_cnt();
        chk("sticky_accum", err_sticky, exp_sticky);

        clr = 1; tick(); clr = 0;
        exp_sticky = 0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        chk("clr_sticky", err_sticky, 0);
        chk("clr_code", err_code, 0);
        chk("clr_class", err_class, 0);
        chk_cnt();

        do_div(ALU_DIVU, 1, 0);
        settle("sb_div_timeout");
        chk("timeout_sticky", err_sticky, 4'b0010);

        // Overlap: a new op accepted while the divide is still outstanding.
        bump(1);
        alu_en = 1; alu_op = ALU_DIV; ex_ready = 0;
        tick();
        clear_inputs();
        tick();
        ex_ready = 1;
        tick();
        alu_en = 1; alu_op = ALU_ADD; ex_valid = 1;
        bump(0);
        expect_err(3'd5, 2'd1);
        tick();
        clear_inputs();
        settle("sb_overlap");
        chk("overlap_sticky", err_sticky, 4'b0010);
        chk_cnt();

        // Reset with a divide in flight must stay silent.
        alu_en = 1; alu_op = ALU_DIV; ex_ready = 0;
        tick();
        clear_inputs();
        repeat (4) tick();
        rst = 1; tick(); rst = 0;
        exp_sticky = 0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 0;
        ex_ready = 1;
        repeat (40) tick();
        do_alu(ALU_ADD, 1, 0);
        settle("sb_rst_mid_op");
        chk("rst_mid_sticky", err_sticky, 0);
        chk_cnt();

        alu_en = 1; alu_op = ALU_ADD; ex_valid = 1; ex_ready = 1;
        repeat (65534) begin
            tick();
            bump(0);
        end
        chk("cnt0_full", issue_cnt[15:0], 16'hFFFF);
        tick();
        bump(0);
        clear_inputs();
        chk("cnt0_saturated", issue_cnt[15:0], 16'hFFFF);
        chk_cnt();
        settle("sb_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
